// File: rtl/tetris_line_clear_pkg.sv
// Shared types and constants for the scene line-clear engine and its score accumulator.
// The score table is only consumed when TETRIS_SCORE_EN is defined.
package tetris_line_clear_pkg;

  localparam int scene_width_c  = 16;
  localparam int scene_height_c = 32;

  typedef enum logic [1:0] {eIdle, eScan, eFill, eDone} line_clear_state_e;

  typedef logic [scene_width_c-1:0] row_t;

  // Points awarded per pass, indexed by min(lines cleared, 4)
  localparam logic [31:0] score_table_c [5] = '{32'd0, 32'd100, 32'd300, 32'd500, 32'd800};

  function automatic logic [31:0] score_points(input int unsigned lines);
    logic [2:0] idx;
    idx = (lines >= 4) ? 3'd4 : 3'(lines);
    return score_table_c[idx];
  endfunction

endpackage

// File: rtl/tetris_line_clear_score_acc.sv
// Saturating 32-bit score accumulator fed with the line count of each finished pass.
// Only built when TETRIS_SCORE_EN is defined.
`ifdef TETRIS_SCORE_EN
module tetris_line_clear_score_acc
  import tetris_line_clear_pkg::*;
#(
  parameter int cnt_w = 6
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             add_i,
  input  logic [cnt_w-1:0] cnt_i,
  output logic [31:0]      score_o
);

  logic [31:0] score_q, score_d;
  logic [32:0] sum;

  always_comb begin
    sum     = {1'b0, score_q} + {1'b0, score_points(int'(cnt_i))};
    score_d = score_q;
    if (add_i) begin
      score_d = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score_o = score_q;

endmodule
`endif

// File: rtl/tetris_line_clear.sv
// Line-clear engine: scans the scene bottom-up, compacts non-full rows downward and zero-fills the top.
// Optional feature macro: TETRIS_SCORE_EN adds score_o and a saturating score accumulator.
module tetris_line_clear
  import tetris_line_clear_pkg::*;
#(
  parameter int scene_width_p  = scene_width_c,
  parameter int scene_height_p = scene_height_c,
  localparam int addr_w = $clog2(scene_height_p),
  localparam int cnt_w  = $clog2(scene_height_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  output logic                     ready_o,
  output logic [addr_w-1:0]        rd_addr_o,
  input  logic [scene_width_p-1:0] rd_data_i,
  output logic                     wr_en_o,
  output logic [addr_w-1:0]        wr_addr_o,
  output logic [scene_width_p-1:0] wr_data_o,
  output logic                     done_o,
  output logic [cnt_w-1:0]         lines_o
`ifdef TETRIS_SCORE_EN
  ,
  output logic [31:0]              score_o
`endif
);

  localparam logic [addr_w-1:0]        last_row_c = addr_w'(scene_height_p - 1);
  localparam logic signed [addr_w:0]   wp_top_c   = $signed((addr_w+1)'(scene_height_p - 1));
  localparam logic signed [addr_w:0]   wp_one_c   = $signed((addr_w+1)'(1));
  localparam logic [cnt_w-1:0]         height_c   = cnt_w'(scene_height_p);

  line_clear_state_e state_q, state_d;
  logic [addr_w-1:0]        rp_q, rp_d;
  // Write pointer carries a sign bit so an underflow is observable rather than wrapping
  logic signed [addr_w:0]   wp_q, wp_d;
  logic [cnt_w-1:0]         cnt_q, cnt_d;
  logic [cnt_w-1:0]         idx_q, idx_d;
  logic [cnt_w-1:0]         lines_q, lines_d;

  always_comb begin
    state_d   = state_q;
    rp_d      = rp_q;
    wp_d      = wp_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    lines_d   = lines_q;
    ready_o   = 1'b0;
    rd_addr_o = rp_q;
    wr_en_o   = 1'b0;
    wr_addr_o = wp_q[addr_w-1:0];
    wr_data_o = '0;
    done_o    = 1'b0;

    unique case (state_q)
      eIdle: begin
        ready_o   = 1'b1;
        rd_addr_o = last_row_c;
        if (v_i) begin
          rp_d    = last_row_c;
          wp_d    = wp_top_c;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = eScan;
        end
      end
      eScan: begin
        // idx_q==0 has no returned data yet; idx_q==H only drains the row-0 result
        if (rp_q != '0) rp_d = rp_q - addr_w'(1);
        idx_d = idx_q + cnt_w'(1);
        if (idx_q != '0) begin
          if (&rd_data_i) begin
            cnt_d = cnt_q + cnt_w'(1);
          end else begin
            wr_en_o   = 1'b1;
            wr_data_o = rd_data_i;
            wp_d      = wp_q - wp_one_c;
          end
        end
        if (idx_q == height_c) begin
          state_d = (cnt_d != '0) ? eFill : eDone;
        end
      end
      eFill: begin
        wr_en_o = 1'b1;
        wp_d    = wp_q - wp_one_c;
        if (wp_q == '0) state_d = eDone;
      end
      eDone: begin
        done_o  = 1'b1;
        lines_d = cnt_q;
        rp_d    = last_row_c;
        state_d = eIdle;
      end
      default: state_d = eIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eIdle;
      rp_q    <= last_row_c;
      wp_q    <= wp_top_c;
      cnt_q   <= '0;
      idx_q   <= '0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lines_q <= lines_d;
    end
  end

  assign lines_o = lines_q;

  wp_no_wrap_a: assert property (@(posedge clk_i) disable iff (reset_i) wr_en_o |-> (wp_q >= 0));

`ifdef TETRIS_SCORE_EN
  tetris_line_clear_score_acc #(
    .cnt_w (cnt_w)
  ) u_score (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .add_i   (state_q == eDone),
    .cnt_i   (cnt_q),
    .score_o (score_o)
  );
`endif

endmodule

// File: tb/tb_tetris_line_clear.sv
// Bench for tetris_line_clear: table-driven scenes, randomized scenes against a queue-based model,
// held-request and mid-pass reset sequences.
module tb_tetris_line_clear;

  localparam int W  = 16;
  localparam int H  = 32;
  localparam int AW = 5;
  localparam int CW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i, v_i, ready_o, wr_en_o, done_o;
  logic [AW-1:0] rd_addr_o, wr_addr_o;
  logic [W-1:0]  rd_data_i, wr_data_o;
  logic [CW-1:0] lines_o;
`ifdef TETRIS_SCORE_EN
  logic [31:0]   score_o;
`endif

  tetris_line_clear #(.scene_width_p(W), .scene_height_p(H)) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .rd_addr_o (rd_addr_o),
    .rd_data_i (rd_data_i),
    .wr_en_o   (wr_en_o),
    .wr_addr_o (wr_addr_o),
    .wr_data_o (wr_data_o),
    .done_o    (done_o),
    .lines_o   (lines_o)
`ifdef TETRIS_SCORE_EN
    ,
    .score_o   (score_o)
`endif
  );

  // Scene RAM: one-cycle read latency, separate write port, bulk load from img
  logic [W-1:0] mem     [H];
  logic [W-1:0] img     [H];
  logic [W-1:0] exp_img [H];
  logic         ld_all;

  always_ff @(posedge clk) begin
    rd_data_i <= mem[rd_addr_o];
    if (ld_all) begin
      for (int i = 0; i < H; i++) mem[i] <= img[i];
    end else if (wr_en_o) begin
      mem[wr_addr_o] <= wr_data_o;
    end
  end

  int total = 0;
  int bad   = 0;
  int model_lines;
  longint unsigned exp_score = 0;

  typedef struct {
    logic [31:0] full_mask;
    int          exp_lines;
    int          exp_lat;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: keep non-full rows bottom-up in a queue, re-stack them from the bottom, zero the rest
  task automatic build_expected();
    logic [W-1:0] q[$];
    model_lines = 0;
    for (int r = H - 1; r >= 0; r--) begin
      if (img[r] == {W{1'b1}}) model_lines++;
      else q.push_back(img[r]);
    end
    for (int r = H - 1; r >= 0; r--) begin
      if (q.size() > 0) exp_img[r] = q.pop_front();
      else exp_img[r] = '0;
    end
  endtask

  task automatic set_scene(input logic [31:0] mask, input bit rnd);
    logic [W-1:0] d;
    for (int r = 0; r < H; r++) begin
      if (mask[r]) begin
        img[r] = {W{1'b1}};
      end else begin
        if (rnd) begin
          d = W'($urandom);
          if (d == {W{1'b1}}) d = 16'hFFFE;
        end else if (r == 29) begin
          d = 16'h0001;
        end else begin
          d = W'(r * 257 + 16);
        end
        img[r] = d;
      end
    end
    @(negedge clk); ld_all = 1'b1;
    @(negedge clk); ld_all = 1'b0;
  endtask

  task automatic score_update(input int lines);
    longint unsigned pts;
    pts = (lines >= 4) ? 800 : (lines == 3) ? 500 : (lines == 2) ? 300 : (lines == 1) ? 100 : 0;
    exp_score = exp_score + pts;
    if (exp_score > 64'hFFFF_FFFF) exp_score = 64'hFFFF_FFFF;
  endtask

  task automatic check_scene(input string tag);
    int nmis = 0;
    for (int r = 0; r < H; r++) if (mem[r] !== exp_img[r]) nmis++;
    check({tag, " scene_rows_wrong"}, nmis, 0);
  endtask

  // One pass; with hold the request stays high and a second pass on the compacted scene follows
  task automatic run_pass(input string tag, input int exp_lines, input int exp_lat, input bit hold);
    int lat, wrs, rdy_busy;
    bit seen;
    build_expected();
    @(negedge clk);
    v_i = 1'b1;
    check({tag, " ready_before"}, ready_o, 1);
    lat = 0; wrs = 0; rdy_busy = 0; seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk); lat++; #1;
      if (!hold) v_i = 1'b0;
      if (wr_en_o) wrs++;
      if (ready_o) rdy_busy++;
      if (done_o) seen = 1'b1;
    end
    check({tag, " done_seen"}, seen, 1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " writes"}, wrs, H);
    check({tag, " ready_busy"}, rdy_busy, 0);
    @(posedge clk); #1;
    check({tag, " lines"}, lines_o, exp_lines);
    check({tag, " ready_after"}, ready_o, 1);
    check_scene(tag);
    score_update(exp_lines);
`ifdef TETRIS_SCORE_EN
    check({tag, " score"}, score_o, exp_score);
`endif
    if (hold) begin
      @(posedge clk); #1;
      check({tag, " second_start"}, ready_o, 0);
      v_i = 1'b0;
      lat = 1; seen = 1'b0;
      while (!seen && lat < 200) begin
        @(posedge clk); lat++; #1;
        if (done_o) seen = 1'b1;
      end
      check({tag, " second_done_seen"}, seen, 1);
      check({tag, " second_latency"}, lat, H + 2);
      @(posedge clk); #1;
      check({tag, " second_lines"}, lines_o, 0);
      check_scene({tag, " second"});
    end
  endtask

  initial begin
    int n;
    reset_i = 1'b1; v_i = 1'b0; ld_all = 1'b0;
    for (int r = 0; r < H; r++) img[r] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", ready_o, 1);
    check("rst wr_en", wr_en_o, 0);
    check("rst done", done_o, 0);
    check("rst lines", lines_o, 0);
    check("rst rd_addr", rd_addr_o, H - 1);
`ifdef TETRIS_SCORE_EN
    check("rst score", score_o, 0);
`endif
    @(negedge clk); reset_i = 1'b0;

    vecs[0] = '{32'h0000_0000, 0,  34};
    vecs[1] = '{32'hC000_0000, 2,  36};
    vecs[2] = '{32'hA800_0000, 3,  37};
    vecs[3] = '{32'hFFFF_FFFF, 32, 66};
    vecs[4] = '{32'h0000_0001, 1,  35};

    for (int i = 0; i < 5; i++) begin
      set_scene(vecs[i].full_mask, 1'b0);
      run_pass($sformatf("vec%0d", i), vecs[i].exp_lines, vecs[i].exp_lat, 1'b0);
      if (i == 1) begin
        check("vec1 row31", mem[31], 16'h0001);
        check("vec1 row1", mem[1], 0);
        check("vec1 row0", mem[0], 0);
      end
    end

    // Reset ten cycles into the scan; previous pass left lines_o at 1
    set_scene(32'hF0F0_0000, 1'b0);
    @(negedge clk); v_i = 1'b1;
    @(posedge clk); #1; v_i = 1'b0;
    repeat (9) @(posedge clk);
    #1; reset_i = 1'b1;
    @(posedge clk); #1;
    check("midrst wr_en", wr_en_o, 0);
    check("midrst ready", ready_o, 1);
    check("midrst lines", lines_o, 0);
    check("midrst rd_addr", rd_addr_o, H - 1);
    reset_i = 1'b0;
    exp_score = 0;
`ifdef TETRIS_SCORE_EN
    check("midrst score", score_o, 0);
`endif
    @(posedge clk); #1;
    check("postrst wr_en", wr_en_o, 0);
    check("postrst done", done_o, 0);

    set_scene(32'h8000_0003, 1'b0);
    run_pass("hold", 3, 37, 1'b1);

    for (int i = 0; i < 15; i++) begin
      set_scene($urandom & $urandom, 1'b1);
      build_expected();
      n = model_lines;
      run_pass($sformatf("rnd%0d", i), n, H + 2 + n, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
